// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Sign cases, indexed by {sign of dividend, sign of divisor}
  localparam logic [1:0] SGN_PP = 2'b00;
  localparam logic [1:0] SGN_PN = 2'b01;
  localparam logic [1:0] SGN_NP = 2'b10;
  localparam logic [1:0] SGN_NN = 2'b11;

  // Width of a down-counter that must hold n-1
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Euclidean sign correction of the unsigned quotient/remainder pair.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int unsigned DVD_W = 8,
  parameter int unsigned DVS_W = 4
) (
  input  logic [DVD_W-1:0] uq,
  input  logic [DVS_W-1:0] ur,
  input  logic             sgn_dvd,
  input  logic             sgn_dvs,
  input  logic [DVS_W:0]   dvs_abs,
  output logic [DVD_W-1:0] q,
  output logic [DVS_W-1:0] r
);

  logic [DVD_W-1:0] uq_inc;
  logic [DVS_W-1:0] r_wrap;

  assign uq_inc = uq + DVD_W'(1);
  assign r_wrap = DVS_W'(dvs_abs - {1'b0, ur});

  always_comb begin
    q = uq;
    r = ur;
    // A zero divisor keeps the raw restoring result (all-ones quotient)
    if (dvs_abs == '0) begin
      q = uq;
      r = ur;
    end else if (ur == '0) begin
      q = (sgn_dvd ^ sgn_dvs) ? -uq : uq;
      r = '0;
    end else begin
      case ({sgn_dvd, sgn_dvs})
        SGN_PP: begin q = uq;      r = ur;     end
        SGN_PN: begin q = -uq;     r = ur;     end
        SGN_NP: begin q = -uq_inc; r = r_wrap; end
        SGN_NN: begin q = uq_inc;  r = r_wrap; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle restoring signed divider with Euclidean results.
// Optional divide-by-zero detection when DIV_ZERO_DET_EN is defined.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int unsigned DVD_W = 8,
  parameter int unsigned DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder
`ifdef DIV_ZERO_DET_EN
  ,
  output logic             div_zero
`endif
);

  localparam int unsigned CNT_W = cnt_w(DVD_W);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sgn_dvd;
  logic             sgn_dvs;
  logic [DVD_W:0]   dvd_mag;
  logic [DVS_W:0]   dvs_abs;
  logic [DVS_W:0]   part;
  logic [DVD_W-1:0] uq;

  logic [DVD_W:0]   dvd_ext_c;
  logic [DVD_W:0]   dvd_abs_c;
  logic [DVS_W:0]   dvs_ext_c;
  logic [DVS_W:0]   dvs_abs_c;
  logic [DVS_W:0]   part_sh_c;
  logic             ge_c;
  logic [DVS_W-1:0] ur_c;
  logic [DVD_W-1:0] q_c;
  logic [DVS_W-1:0] r_c;

  // Magnitudes are one bit wider so the most negative operand is exact
  assign dvd_ext_c = {dividend[DVD_W-1], dividend};
  assign dvd_abs_c = dividend[DVD_W-1] ? -dvd_ext_c : dvd_ext_c;
  assign dvs_ext_c = {divisor[DVS_W-1], divisor};
  assign dvs_abs_c = divisor[DVS_W-1] ? -dvs_ext_c : dvs_ext_c;

  assign part_sh_c = (DVS_W+1)'({part, dvd_mag[DVD_W-1]});
  assign ge_c      = (part_sh_c >= dvs_abs);
  assign ur_c      = DVS_W'(part);

  div_sign_fix #(
    .DVD_W(DVD_W),
    .DVS_W(DVS_W)
  ) u_fix (
    .uq     (uq),
    .ur     (ur_c),
    .sgn_dvd(sgn_dvd),
    .sgn_dvs(sgn_dvs),
    .dvs_abs(dvs_abs),
    .q      (q_c),
    .r      (r_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sgn_dvd   <= 1'b0;
      sgn_dvs   <= 1'b0;
      dvd_mag   <= '0;
      dvs_abs   <= '0;
      part      <= '0;
      uq        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_DET_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sgn_dvd <= dividend[DVD_W-1];
            sgn_dvs <= divisor[DVS_W-1];
            dvd_mag <= dvd_abs_c;
            dvs_abs <= dvs_abs_c;
            part    <= '0;
            uq      <= '0;
            cnt     <= CNT_W'(DVD_W - 1);
`ifdef DIV_ZERO_DET_EN
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '0;
              remainder <= '0;
              div_zero  <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
`else
            state <= CALC;
            busy  <= 1'b1;
`endif
          end
        end
        CALC: begin
          // One restoring step: shift in next dividend bit, subtract if it fits
          part    <= ge_c ? (part_sh_c - dvs_abs) : part_sh_c;
          uq      <= {uq[DVD_W-2:0], ge_c};
          dvd_mag <= dvd_mag << 1;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quotient  <= q_c;
          remainder <= r_c;
          done      <= 1'b1;
          busy      <= 1'b0;
`ifdef DIV_ZERO_DET_EN
          div_zero  <= 1'b0;
`endif
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider against a Euclidean integer model.
module tb_seq_signed_divider;

  localparam int NORM_LAT = 10;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef DIV_ZERO_DET_EN
  logic       div_zero;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_signed_divider #(.DVD_W(8), .DVS_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder)
`ifdef DIV_ZERO_DET_EN
    ,
    .div_zero (div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Euclidean division with plain integers; quotient wraps to 8 bits
  function automatic void ref_div(input int a, input int b,
                                  output logic [7:0] q, output logic [3:0] r,
                                  output int lat, output logic dz);
    int qi, ri;
    dz  = 1'b0;
    lat = NORM_LAT;
    if (b == 0) begin
`ifdef DIV_ZERO_DET_EN
      q = 8'h00; r = 4'h0; dz = 1'b1; lat = 1;
`else
      q = 8'hFF; r = 4'((a < 0) ? -a : a);
`endif
    end else begin
      qi = a / b;
      ri = a - qi * b;
      if (ri < 0) begin
        if (b > 0) begin qi = qi - 1; ri = ri + b; end
        else       begin qi = qi + 1; ri = ri - b; end
      end
      q = 8'(qi);
      r = 4'(ri);
    end
  endfunction

  // Launch one division and observe it until done (bounded)
  task automatic run_op(input int a, input int b, output int lat, output logic busy_ok,
                        output logic [7:0] q, output logic [3:0] r, output logic dz);
    @(negedge clk);
    start = 1'b1; dividend = 8'(a); divisor = 4'(b);
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
    lat = -1; busy_ok = 1'b1; q = 'x; r = 'x; dz = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c; q = quotient; r = remainder;
        if (busy !== 1'b0) busy_ok = 1'b0;
`ifdef DIV_ZERO_DET_EN
        dz = div_zero;
`endif
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, quotient, remainder} !== 14'd0)
      $display("FAIL reset_in: got busy=%b done=%b q=%h r=%h want all 0", busy, done, quotient, remainder);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, done, quotient, remainder} !== 14'd0)
      $display("FAIL reset_after: got busy=%b done=%b q=%h r=%h want all 0", busy, done, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    int va[8] = '{100, -100, 100, -100, -128, -128, 0, 127};
    int vb[8] = '{7, 7, -7, -7, -1, 3, -5, -8};
    int lat, elat;
    logic bok, dz, edz;
    logic [7:0] q, eq;
    logic [3:0] r, er;
    for (int i = 0; i < 8; i++) begin
      ref_div(va[i], vb[i], eq, er, elat, edz);
      run_op(va[i], vb[i], lat, bok, q, r, dz);
      total_cnt++;
      if (lat != elat || !bok || q !== eq || r !== er)
        $display("FAIL directed %0d/%0d: got lat=%0d busy_ok=%b q=%h r=%h want lat=%0d busy_ok=1 q=%h r=%h",
                 va[i], vb[i], lat, bok, q, r, elat, eq, er);
      else pass_cnt++;
    end
    // Results stay held after the done pulse
    repeat (3) @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || quotient !== 8'hF1 || remainder !== 4'h7)
      $display("FAIL hold: got done=%b q=%h r=%h want done=0 q=f1 r=7", done, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int a, b, lat, elat;
    logic bok, dz, edz;
    logic [7:0] q, eq;
    logic [3:0] r, er;
    for (int i = 0; i < 40; i++) begin
      a = int'($signed(8'($urandom)));
      do b = int'($signed(4'($urandom))); while (b == 0);
      ref_div(a, b, eq, er, elat, edz);
      run_op(a, b, lat, bok, q, r, dz);
      total_cnt++;
      if (lat != elat || !bok || q !== eq || r !== er)
        $display("FAIL random %0d/%0d: got lat=%0d busy_ok=%b q=%h r=%h want lat=%0d q=%h r=%h",
                 a, b, lat, bok, q, r, elat, eq, er);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    logic [7:0] q;
    logic [3:0] r;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 4'd7;
    @(posedge clk); #1 start = 1'b0;
    lat = -1; q = 'x; r = 'x; extra = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 4) begin
        start = 1'b1; dividend = 8'(-50); divisor = 4'd3;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); c++;
      end
      if (done) begin lat = c; q = quotient; r = remainder; break; end
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    total_cnt++;
    if (lat != NORM_LAT || q !== 8'd14 || r !== 4'd2 || extra != 0)
      $display("FAIL ignore_start: got lat=%0d q=%h r=%h extra_done=%0d want lat=10 q=0e r=2 extra_done=0",
               lat, q, r, extra);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int dones, lat, elat;
    logic bok, dz, edz;
    logic [7:0] q, eq;
    logic [3:0] r, er;
    @(negedge clk);
    start = 1'b1; dividend = 8'(-100); divisor = 4'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, quotient, remainder} !== 14'd0)
      $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h want all 0", busy, done, quotient, remainder);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    total_cnt++;
    if (dones != 0)
      $display("FAIL reset_no_done: got %0d active cycles want 0", dones);
    else pass_cnt++;
    ref_div(-100, -7, eq, er, elat, edz);
    run_op(-100, -7, lat, bok, q, r, dz);
    total_cnt++;
    if (lat != elat || !bok || q !== eq || r !== er)
      $display("FAIL reset_fresh: got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h", lat, q, r, elat, eq, er);
    else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int lat, elat;
    logic bok, dz, edz;
    logic [7:0] q, eq;
    logic [3:0] r, er;
    ref_div(37, 0, eq, er, elat, edz);
    run_op(37, 0, lat, bok, q, r, dz);
    total_cnt++;
    if (lat != elat || q !== eq || r !== er || dz !== edz)
      $display("FAIL div_zero: got lat=%0d q=%h r=%h dz=%b want lat=%0d q=%h r=%h dz=%b",
               lat, q, r, dz, elat, eq, er, edz);
    else pass_cnt++;
`ifdef DIV_ZERO_DET_EN
    total_cnt++;
    if (busy !== 1'b0 || div_zero !== 1'b1)
      $display("FAIL div_zero_hold: got busy=%b dz=%b want busy=0 dz=1", busy, div_zero);
    else pass_cnt++;
`endif
    run_op(-37, 5, lat, bok, q, r, dz);
    total_cnt++;
    if (lat != NORM_LAT || q !== 8'(-8) || r !== 4'd3 || dz !== 1'b0)
      $display("FAIL div_zero_clear: got lat=%0d q=%h r=%h dz=%b want lat=10 q=f8 r=3 dz=0", lat, q, r, dz);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, elat, lat2;
    logic bok, dz, edz;
    logic [7:0] q, eq;
    logic [3:0] r, er;
    run_op(55, 6, lat, bok, q, r, dz);
    // Now in the done cycle: start here must wait until the next cycle
    start = 1'b1; dividend = 8'(-77); divisor = 4'(-6);
    @(posedge clk);
    @(posedge clk); #1 start = 1'b0;
    ref_div(-77, -6, eq, er, elat, edz);
    lat2 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin lat2 = c; q = quotient; r = remainder; break; end
    end
    total_cnt++;
    if (lat2 != elat || q !== eq || r !== er)
      $display("FAIL back_to_back: got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h", lat2, q, r, elat, eq, er);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_div_zero();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
